// File: rtl/ifetch_buffer.sv
// ifetch_buffer: in-order instruction fetch queue between the PC register and decode.
// Issues fetches at pc_in, collects in-order responses, and hands {pc, instr} to decode.
// Stale responses that were in flight at a redirect (flush) are counted and discarded.
// Optional macro IFB_BYPASS_EN: forward a response straight to decode when the queue
// holds no filled entry (zero-cycle response-to-decode latency).
module ifetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              pc_in,
  output logic [31:0]              pc4,
  output logic                     pc_hold,
  input  logic                     flush,
  output logic                     imem_req_valid,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic                     if_valid,
  output logic [31:0]              if_pc,
  output logic [31:0]              if_instr,
  input  logic                     if_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0]   DEPTH_W = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] ONE     = {{(PW - 1){1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] drop_cnt;

  logic [PW-1:0] filled;
  logic [PW-1:0] outstanding;
  logic [PW:0]   committed;

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] fill_idx;
  logic [AW-1:0] rd_idx;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic issue;
  logic pop;
  logic rsp_has_target;
  logic rsp_stale;
  logic rsp_write;
  logic rsp_drop;

  assign wr_idx   = wr_ptr[AW-1:0];
  assign fill_idx = fill_ptr[AW-1:0];
  assign rd_idx   = rd_ptr[AW-1:0];

  assign occupancy   = wr_ptr - rd_ptr;
  assign filled      = fill_ptr - rd_ptr;
  assign outstanding = wr_ptr - fill_ptr;

  // Slots still owed to stale responses count against capacity, so a new
  // request never races an old response for the same entry.
  assign committed = {1'b0, occupancy} + {1'b0, drop_cnt};

  assign imem_req_valid = rst_n & ~flush & (committed < DEPTH_W);
  assign imem_req_addr  = pc_in;
  assign issue          = imem_req_valid & imem_req_ready;

  assign pc4 = pc_in + 32'd4;

  // The PC register loads on an accepted fetch or a redirect; reset forces a hold.
  assign pc_hold = ~(issue | (flush & rst_n));

  // A response belongs to the oldest live request only when no stale ones are pending.
  assign rsp_has_target = (drop_cnt == '0) && (outstanding != '0);
  assign rsp_stale      = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_write      = imem_rsp_valid && rsp_has_target && !flush;
  assign rsp_drop       = rsp_stale || (imem_rsp_valid && rsp_has_target && flush);

  assign pop = if_valid && if_ready && !flush;

`ifdef IFB_BYPASS_EN
  logic bypass;

  // With nothing filled, fill_ptr equals rd_ptr, so the head pc slot is the one
  // the arriving response belongs to; if popped, the normal write is harmless.
  assign bypass   = imem_rsp_valid && rsp_has_target && !flush && (filled == '0);
  assign if_valid = (filled != '0) || bypass;
  assign if_pc    = pc_mem[rd_idx];
  assign if_instr = bypass ? imem_rsp_data : instr_mem[rd_idx];
`else
  assign if_valid = (filled != '0);
  assign if_pc    = pc_mem[rd_idx];
  assign if_instr = instr_mem[rd_idx];
`endif

  // Pointer updates: issue, fill and pop move independently; a flush discards
  // everything allocated by snapping fill and read up to the issue pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
    end else begin
      if (issue) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (flush) begin
        fill_ptr <= wr_ptr;
        rd_ptr   <= wr_ptr;
      end else begin
        if (rsp_write) begin
          fill_ptr <= fill_ptr + ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + ONE;
        end
      end
    end
  end

  // Stale-response counter: grows by the in-flight count on a redirect and
  // shrinks by one for each response absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= drop_cnt + outstanding - {{(PW - 1){1'b0}}, rsp_drop};
    end else if (rsp_stale) begin
      drop_cnt <= drop_cnt - ONE;
    end
  end

  // Entry storage: the pc is captured at issue, the instruction at fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      if (issue) begin
        pc_mem[wr_idx] <= pc_in;
      end
      if (rsp_write) begin
        instr_mem[fill_idx] <= imem_rsp_data;
      end
    end
  end

endmodule
